// File: rtl/aes_pkg.sv
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES types, round constants and GF(2^8) arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

    typedef logic [31:0] word_t;

    localparam int NUM_ROUNDS = 10;

    // Round constant; indices past the last round yield zero.
    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_inv_sbox_lut.sv
// ============================================================================
// Module      : aes_inv_sbox_lut
// Description : Inverse AES S-box: inverse affine map, then GF(2^8) inverse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_inv_sbox_lut
    import aes_pkg::*;
(
    input  logic [7:0] i_a,
    output logic [7:0] o_d
);

    logic [7:0] w_aff;

    assign w_aff = {i_a[6:0], i_a[7]}
                 ^ {i_a[4:0], i_a[7:5]}
                 ^ {i_a[1:0], i_a[7:2]}
                 ^ 8'h05;
    assign o_d   = gf_inv(w_aff);

endmodule

`default_nettype wire

// File: rtl/aes_sbox.sv
// ============================================================================
// Module      : aes_sbox
// Description : Forward AES S-box: GF(2^8) inverse followed by affine map.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_a,
    output logic [7:0] o_d
);

    logic [7:0] w_inv;

    assign w_inv = gf_inv(i_a);
    assign o_d   = w_inv
                 ^ {w_inv[6:0], w_inv[7]}
                 ^ {w_inv[5:0], w_inv[7:6]}
                 ^ {w_inv[4:0], w_inv[7:5]}
                 ^ {w_inv[3:0], w_inv[7:4]}
                 ^ 8'h63;

endmodule

`default_nettype wire

// File: rtl/aes_dec_key_sbox.sv
// ============================================================================
// Module      : aes_dec_key_sbox
// Description : AES-128 round-key expansion (one key per clock) plus a
//               combinational inverse S-box lookup port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_dec_key_sbox
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         kld,
    input  logic [127:0] key,
    output logic [31:0]  wo_0,
    output logic [31:0]  wo_1,
    output logic [31:0]  wo_2,
    output logic [31:0]  wo_3,
    input  logic [7:0]   sbox_a,
    output logic [7:0]   sbox_d
);

    localparam logic [3:0] C_RCNT_MAX = 4'(NUM_ROUNDS);

    word_t      r_w0, r_w1, r_w2, r_w3;
    logic [3:0] r_rcnt;

    word_t      w_rot, w_sub, w_t;
    word_t      w_n0, w_n1, w_n2, w_n3;

    assign w_rot = {r_w3[23:0], r_w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_subword
        aes_sbox u_sbox (
            .i_a (w_rot[8*i +: 8]),
            .o_d (w_sub[8*i +: 8])
        );
    end

    assign w_t  = w_sub ^ {rcon_of(r_rcnt), 24'h0};
    assign w_n0 = r_w0 ^ w_t;
    assign w_n1 = w_n0 ^ r_w1;
    assign w_n2 = w_n1 ^ r_w2;
    assign w_n3 = w_n2 ^ r_w3;

    // Free-running: keeps expanding past the last round with rcon 00.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_w0   <= '0;
            r_w1   <= '0;
            r_w2   <= '0;
            r_w3   <= '0;
            r_rcnt <= '0;
        end else if (kld) begin
            r_w0   <= key[127:96];
            r_w1   <= key[95:64];
            r_w2   <= key[63:32];
            r_w3   <= key[31:0];
            r_rcnt <= '0;
        end else begin
            r_w0   <= w_n0;
            r_w1   <= w_n1;
            r_w2   <= w_n2;
            r_w3   <= w_n3;
            if (r_rcnt != C_RCNT_MAX) r_rcnt <= r_rcnt + 4'd1;
        end
    end

    assign wo_0 = r_w0;
    assign wo_1 = r_w1;
    assign wo_2 = r_w2;
    assign wo_3 = r_w3;

    aes_inv_sbox_lut u_inv_sbox (
        .i_a (sbox_a),
        .o_d (sbox_d)
    );

endmodule

`default_nettype wire

// File: tb/tb_aes_dec_key_sbox.sv
// ============================================================================
// Module      : tb_aes_dec_key_sbox
// Description : Directed self-checking bench for aes_dec_key_sbox.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_dec_key_sbox;

    logic         clk = 1'b0;
    logic         rst;
    logic         kld;
    logic [127:0] key;
    logic [31:0]  wo_0, wo_1, wo_2, wo_3;
    logic [7:0]   sbox_a;
    logic [7:0]   sbox_d;

    int n_vec = 0;
    int n_err = 0;

    logic [0:255][7:0] fwd_tbl;
    logic [127:0]      k_fips;

    always #5 clk = ~clk;

    aes_dec_key_sbox dut (
        .clk    (clk),
        .rst    (rst),
        .kld    (kld),
        .key    (key),
        .wo_0   (wo_0),
        .wo_1   (wo_1),
        .wo_2   (wo_2),
        .wo_3   (wo_3),
        .sbox_a (sbox_a),
        .sbox_d (sbox_d)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_k(input string tag, input logic [127:0] exp);
        chk_w({tag, ".w0"}, wo_0, exp[127:96]);
        chk_w({tag, ".w1"}, wo_1, exp[95:64]);
        chk_w({tag, ".w2"}, wo_2, exp[63:32]);
        chk_w({tag, ".w3"}, wo_3, exp[31:0]);
    endtask

    task automatic chk_b(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        fwd_tbl = {
            128'h637c777bf26b6fc53001672bfed7ab76,
            128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115,
            128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84,
            128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8,
            128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973,
            128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479,
            128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
            128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df,
            128'h8ca1890dbfe6426841992d0fb054bb16
        };
        k_fips = 128'h2b7e151628aed2a6abf7158809cf4f3c;

        rst    = 1'b1;
        kld    = 1'b0;
        key    = '0;
        sbox_a = 8'h00;
        tick();
        chk_k("reset", 128'h0);

        // FIPS-197 key expansion
        rst = 1'b0;
        kld = 1'b1;
        key = k_fips;
        tick();
        chk_k("fips_r0", k_fips);
        kld = 1'b0;
        tick();
        chk_k("fips_r1", 128'ha0fafe1788542cb123a339392a6c7605);
        for (int i = 2; i <= 10; i++) tick();
        chk_k("fips_r10", 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // All-zero key
        kld = 1'b1;
        key = '0;
        tick();
        chk_k("zero_r0", 128'h0);
        kld = 1'b0;
        tick();
        chk_k("zero_r1", {4{32'h62636363}});
        tick();
        chk_w("zero_r2.w0", wo_0, 32'h9b9898c9);

        // Reload at round 5, then reset
        kld = 1'b1;
        key = k_fips;
        tick();
        kld = 1'b0;
        for (int i = 1; i <= 5; i++) tick();
        kld = 1'b1;
        tick();
        chk_k("reload_r0", k_fips);
        kld = 1'b0;
        tick();
        chk_k("reload_r1", 128'ha0fafe1788542cb123a339392a6c7605);
        rst = 1'b1;
        kld = 1'b1;
        tick();
        chk_k("rst_over_kld", 128'h0);
        kld = 1'b0;
        tick();
        chk_k("rst_hold", 128'h0);
        rst = 1'b0;
        tick();
        chk_k("rst_then_adv", {4{32'h62636363}});

        // Inverse S-box spot checks
        sbox_a = 8'h00; #1; chk_b("isb_00", sbox_d, 8'h52);
        sbox_a = 8'h01; #1; chk_b("isb_01", sbox_d, 8'h09);
        sbox_a = 8'h63; #1; chk_b("isb_63", sbox_d, 8'h00);
        sbox_a = 8'h7c; #1; chk_b("isb_7c", sbox_d, 8'h01);
        sbox_a = 8'h16; #1; chk_b("isb_16", sbox_d, 8'hff);
        sbox_a = 8'hff; #1; chk_b("isb_ff", sbox_d, 8'h7d);

        // Inverse S-box sweep against the forward table
        for (int x = 0; x < 256; x++) begin
            sbox_a = fwd_tbl[x];
            #1;
            chk_b($sformatf("isb_sweep_%02h", x[7:0]), sbox_d, x[7:0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
